// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: instruction-index width, word shift and PC width.
package cpu_pkg;

    localparam int CPU_SRC_W = 26;
    localparam int CPU_SH    = 2;
    localparam int CPU_PC_W  = 32;

    // Selects the PC bits above the jump field; they come from pc_plus4.
    function automatic logic [CPU_PC_W-1:0] upper_mask(input int field_w);
        logic [CPU_PC_W-1:0] m;
        m = '1;
        for (int i = 0; i < CPU_PC_W; i++)
            if (i < field_w) m[i] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/shl2.sv
// Jump-target builder: word index shifted to a byte address (pure wiring), merged
// with the upper PC bits and registered with a stall-able valid.
module shl2
    import cpu_pkg::*;
#(
    parameter int SRC_W = CPU_SRC_W,
    parameter int SH    = CPU_SH,
    parameter int PC_W  = CPU_PC_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SRC_W-1:0]      src,
    output logic [SRC_W+SH-1:0]   dst,
    input  logic [PC_W-1:0]       pc_plus4,
    input  logic                  in_valid,
    input  logic                  stall,
    output logic [PC_W-1:0]       target,
    output logic                  target_valid
);

    localparam int DW = SRC_W + SH;

    // Mask form avoids a zero-width slice when PC_W == SRC_W + SH.
    localparam logic [PC_W-1:0] LOW_MASK = {PC_W{1'b1}} >> (PC_W - DW);

    logic [PC_W-1:0] next_target;

    assign dst         = {src, {SH{1'b0}}};
    assign next_target = (pc_plus4 & ~LOW_MASK) | PC_W'(dst);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target       <= '0;
            target_valid <= 1'b0;
        end else if (!stall) begin
            target       <= next_target;
            target_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_shl2.sv
// Self-checking bench for shl2: scoreboard of expected target/valid per clock step.
module tb_shl2;
    import cpu_pkg::*;

    logic        clock;
    logic        reset;
    logic [25:0] src;
    logic [27:0] dst;
    logic [31:0] pc_plus4;
    logic        in_valid;
    logic        stall;
    logic [31:0] target;
    logic        target_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] t;
        logic        v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] m_t;
    logic        m_v;

    shl2 dut (
        .clock        (clock),
        .reset        (reset),
        .src          (src),
        .dst          (dst),
        .pc_plus4     (pc_plus4),
        .in_valid     (in_valid),
        .stall        (stall),
        .target       (target),
        .target_valid (target_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [25:0] s);
        return {pc[31:28], s, 2'b00};
    endfunction

    // Drive one cycle of inputs, push the expected post-edge state, advance past the edge.
    task automatic clock_step(input logic [25:0] s, input logic [31:0] pc,
                              input logic v, input logic st);
        exp_t x;
        src      = s;
        pc_plus4 = pc;
        in_valid = v;
        stall    = st;
        if (reset) begin
            m_t = '0;
            m_v = 1'b0;
        end else if (!st) begin
            m_t = model_target(pc, s);
            m_v = v;
        end
        x.t = m_t;
        x.v = m_v;
        sb.push_back(x);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        src      = '0;
        pc_plus4 = '0;
        in_valid = 1'b0;
        stall    = 1'b0;
        #1 reset = 1'b1;
        src = 26'd23;
        #1;
        checks++;
        if (dst !== 28'd92) begin
            errors++;
            $display("FAIL reset_dst got=%0h want=%0h", dst, 28'd92);
        end
        checks++;
        if (target !== 32'd0 || target_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got=%0h/%0b want=0/0", target, target_valid);
        end
        for (int i = 0; i < 2; i++) begin
            clock_step(26'd23, 32'h4000_1000, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (target !== e.t || target_valid !== e.v || target !== 32'd0) begin
                errors++;
                $display("FAIL reset_hold got=%0h/%0b want=%0h/%0b", target, target_valid, e.t, e.v);
            end
        end
    endtask

    task automatic test_basic();
        reset = 1'b0;
        clock_step(26'd23, 32'h4000_1000, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (target !== e.t || target_valid !== e.v || target !== 32'h4000_005C || target_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_load got=%0h/%0b want=%0h/%0b", target, target_valid, 32'h4000_005C, 1'b1);
        end
    endtask

    task automatic test_all_ones();
        src      = 26'h3FF_FFFF;
        pc_plus4 = 32'hF000_0000;
        #1;
        checks++;
        if (dst !== 28'hFFF_FFFC) begin
            errors++;
            $display("FAIL all_ones_dst got=%0h want=%0h", dst, 28'hFFF_FFFC);
        end
        clock_step(26'h3FF_FFFF, 32'hF000_0000, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (target !== e.t || target_valid !== e.v || target !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL all_ones_target got=%0h want=%0h", target, 32'hFFFF_FFFC);
        end
        clock_step(26'd0, 32'h0000_0000, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (dst !== 28'd0 || target !== e.t || target_valid !== e.v) begin
            errors++;
            $display("FAIL zero_src got=%0h/%0h want=0/%0h", dst, target, e.t);
        end
    endtask

    task automatic test_stall();
        clock_step(26'd5, 32'h1234_5678, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (target !== e.t || target_valid !== e.v || target !== 32'h1000_0014) begin
            errors++;
            $display("FAIL stall_preload got=%0h/%0b want=%0h/1", target, target_valid, 32'h1000_0014);
        end
        for (int i = 1; i <= 3; i++) begin
            src = 26'(i);
            #1;
            checks++;
            if (dst !== 28'(i * 4)) begin
                errors++;
                $display("FAIL stall_dst got=%0h want=%0h", dst, 28'(i * 4));
            end
            clock_step(26'(i), 32'hABCD_0000, 1'(i % 2), 1'b1);
            e = sb.pop_front();
            checks++;
            if (target !== e.t || target_valid !== e.v || target !== 32'h1000_0014 || target_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold got=%0h/%0b want=%0h/1", target, target_valid, 32'h1000_0014);
            end
        end
    endtask

    task automatic test_async_reset();
        clock_step(26'd7, 32'hA000_0000, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (target !== e.t || target_valid !== e.v) begin
            errors++;
            $display("FAIL arst_preload got=%0h/%0b want=%0h/%0b", target, target_valid, e.t, e.v);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (target !== 32'd0 || target_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_clear got=%0h/%0b want=0/0", target, target_valid);
        end
        checks++;
        if (dst !== 28'd28) begin
            errors++;
            $display("FAIL arst_dst got=%0h want=%0h", dst, 28'd28);
        end
        m_t = '0;
        m_v = 1'b0;
        @(posedge clock);
        #1;
        clock_step(26'd9, 32'h5000_0000, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if (target !== e.t || target_valid !== e.v) begin
            errors++;
            $display("FAIL arst_priority got=%0h/%0b want=%0h/%0b", target, target_valid, e.t, e.v);
        end
        reset = 1'b0;
        clock_step(26'd9, 32'h5000_0000, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if (target !== e.t || target_valid !== e.v || target_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_stalled got=%0h/%0b want=%0h/%0b", target, target_valid, e.t, e.v);
        end
        clock_step(26'd9, 32'h5000_0000, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (target !== e.t || target_valid !== e.v || target !== 32'h5000_0024) begin
            errors++;
            $display("FAIL arst_first_load got=%0h/%0b want=%0h/%0b", target, target_valid, e.t, e.v);
        end
    endtask

    task automatic test_invalid();
        clock_step(26'd9, 32'h3000_0000, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (target_valid !== 1'b0 || target !== e.t) begin
            errors++;
            $display("FAIL invalid got=%0h/%0b want=%0h/0", target, target_valid, e.t);
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] s;
        logic [31:0] pc;
        for (int i = 0; i < 40; i++) begin
            s  = 26'($urandom);
            pc = $urandom;
            clock_step(s, pc, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            e = sb.pop_front();
            checks++;
            if (target !== e.t || target_valid !== e.v || target[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL b2b[%0d] got=%0h/%0b want=%0h/%0b", i, target, target_valid, e.t, e.v);
            end
        end
    endtask

    initial begin
        m_t = '0;
        m_v = 1'b0;
        test_reset();
        test_basic();
        test_all_ones();
        test_stall();
        test_async_reset();
        test_invalid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
